regfile_mp: RTL and testbench

Parametrised multi-port general-purpose register file for the MIPS datapath. It is the next generation of the single-write, dual-read register bank. It adds configurable width, depth and port counts, write-to-read bypass, and a per-register pending-write scoreboard that the hazard unit uses for load-use stalls. It sits between decode (read ports, reservations) and writeback (write ports).

---
 rtl/regfile_mp.sv | 100 ++++++++++
 tb/tb_regfile_mp.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Multi-port MIPS register file with write-to-read bypass
// and a per-register pending-write scoreboard for the hazard unit.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  output logic [NUM_REGS-1:0]      busy_vec
);

  localparam logic [ADDR_W:0] LIMIT = NUM_REGS[ADDR_W:0];

  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < LIMIT) && !(ZERO_REG != 0 && a == '0);
  endfunction

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] hit_set;
  logic [NUM_REGS-1:0] hit_clr;
  logic [ADDR_W-1:0]   wa [NUM_WR];
  logic [DATA_W-1:0]   wd [NUM_WR];
  logic [NUM_WR-1:0]   wr_ok;
  logic                rsv_ok;
  logic [ADDR_W-1:0]   ra [NUM_RD];
  logic [NUM_RD-1:0]   byp;

  always_comb begin
    for (int p = 0; p < NUM_WR; p++) begin
      wa[p]    = wr_addr[p*ADDR_W +: ADDR_W];
      wd[p]    = wr_data[p*DATA_W +: DATA_W];
      wr_ok[p] = wr_en[p] && addr_ok(wa[p]);
    end
    rsv_ok = rsv_en && addr_ok(rsv_addr);
  end

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      hit_set[i] = rsv_ok && (rsv_addr == ADDR_W'(i));
      hit_clr[i] = 1'b0;
      for (int p = 0; p < NUM_WR; p++)
        if (wr_ok[p] && wa[p] == ADDR_W'(i))
          hit_clr[i] = 1'b1;
    end
  end

  // Later ports are assigned last, so port 1 wins a same-address conflict.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= '0;
      busy <= '0;
    end else begin
      for (int p = 0; p < NUM_WR; p++)
        if (wr_ok[p])
          regs[wa[p]] <= wd[p];
      busy <= hit_set | (busy & ~hit_clr);
    end
  end

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    byp     = '0;
    for (int r = 0; r < NUM_RD; r++) begin
      ra[r] = rd_addr[r*ADDR_W +: ADDR_W];
      if (addr_ok(ra[r])) begin
        rd_data[r*DATA_W +: DATA_W] = regs[ra[r]];
        rd_busy[r] = busy[ra[r]];
        if (BYPASS != 0) begin
          for (int p = 0; p < NUM_WR; p++)
            if (wr_ok[p] && wa[p] == ra[r]) begin
              rd_data[r*DATA_W +: DATA_W] = wd[p];
              byp[r] = 1'b1;
            end
        end
        // A same-cycle reservation means a newer producer is in flight.
        if (byp[r] && !(rsv_ok && rsv_addr == ra[r]))
          rd_busy[r] = 1'b0;
      end
    end
  end

  assign busy_vec = busy;

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: bypass and non-bypass instances
// driven together and checked against an array-based reference model.
module tb_regfile_mp;

  localparam int NR = 24;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    wr_en;
  logic [2*AW-1:0] wr_addr;
  logic [63:0]   wr_data;
  logic [2*AW-1:0] rd_addr;
  logic [63:0]   rd_data, nb_data;
  logic [1:0]    rd_busy, nb_busy;
  logic          rsv_en;
  logic [AW-1:0] rsv_addr;
  logic [NR-1:0] busy_vec, nb_vec;

  regfile_mp #(
    .DATA_W(32), .NUM_REGS(NR), .NUM_RD(2), .NUM_WR(2),
    .ZERO_REG(1), .BYPASS(1)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_busy(rd_busy), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .busy_vec(busy_vec)
  );

  regfile_mp #(
    .DATA_W(32), .NUM_REGS(NR), .NUM_RD(2), .NUM_WR(2),
    .ZERO_REG(1), .BYPASS(0)
  ) dut_nb (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(nb_data),
    .rd_busy(nb_busy), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .busy_vec(nb_vec)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0]   d;
    logic [1:0]    b;
    logic [63:0]   nd;
    logic [1:0]    nb;
    logic [NR-1:0] bv;
  } exp_t;

  exp_t        q[$];
  logic [31:0] mem [NR];
  bit [NR-1:0] mbusy;
  bit          known = 0;
  int          checks = 0;
  int          errors = 0;

  function automatic void chk(string n, logic [63:0] a, logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h exp %h", n, a, e);
    end
  endfunction

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("rd_data", rd_data, e.d);
      chk("rd_busy", 64'(rd_busy), 64'(e.b));
      chk("nb_rd_data", nb_data, e.nd);
      chk("nb_rd_busy", 64'(nb_busy), 64'(e.nb));
      chk("busy_vec", 64'(busy_vec), 64'(e.bv));
      chk("nb_busy_vec", 64'(nb_vec), 64'(e.bv));
    end
  end

  function automatic bit vld(int a);
    return a > 0 && a < NR;
  endfunction

  task automatic cyc(input bit r, input bit [1:0] we,
                     input int a0, input logic [31:0] d0,
                     input int a1, input logic [31:0] d1,
                     input int ra0, input int ra1,
                     input bit rv, input int rva);
    exp_t e;
    int   ras [2];
    @(posedge clk);
    #1;
    rst      = r;
    wr_en    = we;
    wr_addr  = {a1[AW-1:0], a0[AW-1:0]};
    wr_data  = {d1, d0};
    rd_addr  = {ra1[AW-1:0], ra0[AW-1:0]};
    rsv_en   = rv;
    rsv_addr = rva[AW-1:0];
    ras[0] = ra0;
    ras[1] = ra1;
    e.d  = '0;
    e.b  = '0;
    e.nd = '0;
    e.nb = '0;
    e.bv = mbusy;
    for (int k = 0; k < 2; k++) begin
      int a;
      logic [31:0] v, bv;
      bit b, hit;
      a = ras[k];
      v = '0;
      b = 0;
      bv = '0;
      hit = 0;
      if (vld(a)) begin
        v = mem[a];
        b = mbusy[a];
        e.nd[k*32 +: 32] = v;
        e.nb[k] = b;
        if (we[1] && a1 == a) begin
          v = d1;
          hit = 1;
        end else if (we[0] && a0 == a) begin
          v = d0;
          hit = 1;
        end
        if (hit && !(rv && rva == a))
          b = 0;
      end
      e.d[k*32 +: 32] = v;
      e.b[k] = b;
    end
    if (known)
      q.push_back(e);
    if (r) begin
      for (int i = 0; i < NR; i++)
        mem[i] = '0;
      mbusy = '0;
      known = 1;
    end else begin
      if (we[0] && vld(a0)) begin
        mem[a0] = d0;
        mbusy[a0] = 0;
      end
      if (we[1] && vld(a1)) begin
        mem[a1] = d1;
        mbusy[a1] = 0;
      end
      if (rv && vld(rva))
        mbusy[rva] = 1;
    end
  endtask

  function automatic int raddr();
    if ($urandom_range(0, 3) == 0)
      return int'($urandom_range(0, 31));
    return int'($urandom_range(0, 5));
  endfunction

  initial begin
    int n;
    rst = 1'b1;
    wr_en = '0;
    wr_addr = '0;
    wr_data = '0;
    rd_addr = '0;
    rsv_en = 1'b0;
    rsv_addr = '0;
    cyc(1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 2'b00, 0, 0, 0, 0, 5, 1, 0, 0);
    cyc(0, 2'b01, 5, 32'hDEADBEEF, 0, 0, 5, 1, 1, 6);
    cyc(1, 2'b00, 0, 0, 0, 0, 5, 6, 0, 0);
    cyc(0, 2'b00, 0, 0, 0, 0, 5, 6, 0, 0);
    cyc(0, 2'b01, 7, 32'h12345678, 0, 0, 7, 0, 0, 0);
    cyc(0, 2'b01, 0, 32'hFFFFFFFF, 0, 0, 7, 0, 0, 0);
    cyc(0, 2'b00, 0, 0, 0, 0, 0, 7, 0, 0);
    cyc(0, 2'b01, 9, 32'hA5A5A5A5, 0, 0, 0, 9, 0, 0);
    cyc(0, 2'b00, 0, 0, 0, 0, 0, 9, 0, 0);
    cyc(0, 2'b11, 3, 32'h1, 3, 32'h2, 3, 3, 0, 0);
    cyc(0, 2'b00, 0, 0, 0, 0, 3, 9, 0, 0);
    cyc(0, 2'b00, 0, 0, 0, 0, 4, 3, 1, 4);
    cyc(0, 2'b00, 0, 0, 0, 0, 4, 3, 0, 0);
    cyc(0, 2'b01, 4, 32'h55, 0, 0, 4, 4, 0, 0);
    cyc(0, 2'b00, 0, 0, 0, 0, 4, 0, 1, 4);
    cyc(0, 2'b10, 0, 0, 4, 32'h55, 4, 4, 1, 4);
    cyc(0, 2'b00, 0, 0, 0, 0, 4, 4, 0, 0);
    cyc(0, 2'b11, 30, 32'h77, 0, 32'h66, 30, 0, 0, 0);
    cyc(0, 2'b00, 0, 0, 0, 0, 30, 23, 1, 30);
    cyc(0, 2'b00, 0, 0, 0, 0, 30, 24, 1, 0);
    cyc(0, 2'b00, 0, 0, 0, 0, 0, 30, 0, 0);
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 99) == 0, 2'($urandom_range(0, 3)),
          raddr(), $urandom, raddr(), $urandom,
          raddr(), raddr(), $urandom_range(0, 2) == 0, raddr());
    end
    n = 0;
    while (q.size() > 0 && n < 10) begin
      @(posedge clk);
      n++;
    end
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain pending %0d", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
